// File: rtl/adam_axil_from_obi.sv
// adam_axil_from_obi
// OBI slave to AXI-Lite master bridge. OBI requests are forwarded to the
// AXI-Lite AR channel (reads) or to the AW + W channels (writes) with no
// added latency: gnt is combinational from the AXI ready signals. An in-order
// FIFO of transaction types (1 = write, 0 = read) steers the single OBI
// response channel to either the B or the R channel. The FIFO steers by type
// only, because B and R can return in any relative order.
//
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   req/gnt/addr/we/be/wdata     OBI request channel (slave side)
//   rvalid/rready/rdata          OBI response channel
//   aw_*, w_*, b_*, ar_*, r_*    AXI-Lite master channels
module adam_axil_from_obi #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_TRANS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // OBI slave
  input  logic                      req,
  output logic                      gnt,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_WIDTH-1:0]     rdata,
  // AXI-Lite master: write address
  output logic [ADDR_WIDTH-1:0]     aw_addr,
  output logic [2:0]                aw_prot,
  output logic                      aw_valid,
  input  logic                      aw_ready,
  // AXI-Lite master: write data
  output logic [DATA_WIDTH-1:0]     w_data,
  output logic [DATA_WIDTH/8-1:0]   w_strb,
  output logic                      w_valid,
  input  logic                      w_ready,
  // AXI-Lite master: write response
  input  logic [1:0]                b_resp,
  input  logic                      b_valid,
  output logic                      b_ready,
  // AXI-Lite master: read address
  output logic [ADDR_WIDTH-1:0]     ar_addr,
  output logic [2:0]                ar_prot,
  output logic                      ar_valid,
  input  logic                      ar_ready,
  // AXI-Lite master: read data
  input  logic [DATA_WIDTH-1:0]     r_data,
  input  logic [1:0]                r_resp,
  input  logic                      r_valid,
  output logic                      r_ready
);

  localparam int unsigned PTR_W = $clog2(MAX_TRANS);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_TRANS);

  logic [MAX_TRANS-1:0] type_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q;
  logic                 aw_done_q, w_done_q;

  logic full, empty, head_is_wr, push, pop;

  // Responses are not reported to OBI; OBI has no error signalling here.
  logic unused_resp;
  assign unused_resp = ^{b_resp, r_resp};

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign head_is_wr = type_q[rd_ptr_q];

  assign aw_addr = addr;
  assign ar_addr = addr;
  assign w_data  = wdata;
  assign w_strb  = be;
  assign aw_prot = '0;
  assign ar_prot = '0;

  always_comb begin
    gnt      = 1'b0;
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    rvalid   = 1'b0;
    rdata    = '0;
    b_ready  = 1'b0;
    r_ready  = 1'b0;

    // Request path: explicit rst gating keeps all valids and gnt low while
    // reset is held, independent of what the OBI master drives.
    if (!rst && req && !full) begin
      if (we) begin
        // AW and W complete independently; grant in the cycle the later
        // of the two handshakes happens (or both together).
        aw_valid = !aw_done_q;
        w_valid  = !w_done_q;
        gnt      = (aw_done_q | aw_ready) & (w_done_q | w_ready);
      end else begin
        ar_valid = 1'b1;
        gnt      = ar_ready;
      end
    end

    // Response path steered by the oldest outstanding transaction type.
    if (!rst && !empty) begin
      if (head_is_wr) begin
        rvalid  = b_valid;
        b_ready = rready;
      end else begin
        rvalid  = r_valid;
        rdata   = r_data;
        r_ready = rready;
      end
    end
  end

  assign push = gnt;
  assign pop  = rvalid & rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (push) begin
        type_q[wr_ptr_q] <= we;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (gnt) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_valid && aw_ready) aw_done_q <= 1'b1;
        if (w_valid && w_ready)   w_done_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adam_axil_from_obi.sv
// Testbench for adam_axil_from_obi: directed scenarios with literal
// expectations, then a randomized OBI master / AXI-Lite slave run checked
// every cycle against a queue-based model of outstanding transactions.
module tb_adam_axil_from_obi;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          gnt;
  logic [AW-1:0] addr = '0;
  logic          we = 1'b0;
  logic [DW/8-1:0] be = '0;
  logic [DW-1:0] wdata = '0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [AW-1:0] aw_addr;
  logic [2:0]    aw_prot;
  logic          aw_valid;
  logic          aw_ready = 1'b0;
  logic [DW-1:0] w_data;
  logic [DW/8-1:0] w_strb;
  logic          w_valid;
  logic          w_ready = 1'b0;
  logic [1:0]    b_resp = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [AW-1:0] ar_addr;
  logic [2:0]    ar_prot;
  logic          ar_valid;
  logic          ar_ready = 1'b0;
  logic [DW-1:0] r_data = '0;
  logic [1:0]    r_resp = '0;
  logic          r_valid = 1'b0;
  logic          r_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adam_axil_from_obi #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_TRANS (MT)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .gnt(gnt), .addr(addr), .we(we), .be(be), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0; rready = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = 1'b0; r_valid = 1'b0;
  endtask

  // Model of the bridge as seen from outside: outstanding OBI transactions in
  // grant order, each carrying the response data the OBI master must see.
  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
  } resp_t;

  resp_t       outq[$];
  logic [31:0] slave_rq[$];
  int          b_pend;
  bit          aw_seen, w_seen;
  bit          drop_req, drop_b, drop_r;

  initial begin
    // ---------------- reset behaviour ----------------
    rst = 1'b1;
    req = 1'b1; we = 1'b0; addr = 32'h40; ar_ready = 1'b1; b_valid = 1'b1; r_valid = 1'b1;
    rready = 1'b1;
    step();
    chkb("rst_gnt", gnt, 1'b0);
    chkb("rst_ar_valid", ar_valid, 1'b0);
    chkb("rst_rvalid", rvalid, 1'b0);
    chkw("rst_rdata", rdata, 32'h0);
    chkb("rst_b_ready", b_ready, 1'b0);
    chkb("rst_r_ready", r_ready, 1'b0);
    idle();
    step();
    rst = 1'b0;
    step();

    // ---------------- read ----------------
    req = 1'b1; we = 1'b0; addr = 32'h40; ar_ready = 1'b1;
    settle();
    chkb("rd_gnt", gnt, 1'b1);
    chkb("rd_ar_valid", ar_valid, 1'b1);
    chkw("rd_ar_addr", ar_addr, 32'h40);
    chkw("rd_ar_prot", {29'b0, ar_prot}, 32'h0);
    step();
    idle();
    r_valid = 1'b1; r_data = 32'hDEADBEEF; rready = 1'b1;
    settle();
    chkb("rd_rvalid", rvalid, 1'b1);
    chkw("rd_rdata", rdata, 32'hDEADBEEF);
    chkb("rd_r_ready", r_ready, 1'b1);
    step();
    r_valid = 1'b0;
    settle();
    chkb("rd_done_rvalid", rvalid, 1'b0);

    // ---------------- split write ----------------
    idle();
    req = 1'b1; we = 1'b1; addr = 32'h80; wdata = 32'hA5A5_0011; be = 4'hF;
    aw_ready = 1'b1; w_ready = 1'b0;
    settle();
    chkb("sw_c0_aw_valid", aw_valid, 1'b1);
    chkb("sw_c0_w_valid", w_valid, 1'b1);
    chkb("sw_c0_gnt", gnt, 1'b0);
    chkw("sw_aw_addr", aw_addr, 32'h80);
    chkw("sw_w_data", w_data, 32'hA5A5_0011);
    step();
    aw_ready = 1'b0;
    for (int c = 1; c < 3; c++) begin
      settle();
      chkb("sw_mid_aw_valid", aw_valid, 1'b0);
      chkb("sw_mid_w_valid", w_valid, 1'b1);
      chkb("sw_mid_gnt", gnt, 1'b0);
      step();
    end
    w_ready = 1'b1;
    settle();
    chkb("sw_c3_gnt", gnt, 1'b1);
    step();
    idle();
    b_valid = 1'b1; rready = 1'b1;
    settle();
    chkb("sw_rvalid", rvalid, 1'b1);
    chkw("sw_rdata", rdata, 32'h0);
    chkb("sw_b_ready", b_ready, 1'b1);
    chkb("sw_r_ready", r_ready, 1'b0);
    step();
    b_valid = 1'b0;

    // ---------------- full ----------------
    idle();
    req = 1'b1; we = 1'b0; addr = 32'h200; ar_ready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chkb("full_fill_gnt", gnt, 1'b1);
      step();
    end
    settle();
    chkb("full_gnt", gnt, 1'b0);
    chkb("full_ar_valid", ar_valid, 1'b0);
    step();
    r_valid = 1'b1; r_data = 32'h1;
    settle();
    chkb("full_pop_rvalid", rvalid, 1'b1);
    chkb("full_pop_gnt", gnt, 1'b0);
    step();
    r_valid = 1'b0;
    settle();
    chkb("full_after_pop_gnt", gnt, 1'b1);
    step();
    req = 1'b0; ar_ready = 1'b0;
    r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_data = 32'(i + 2);
      settle();
      chkb("full_drain_rvalid", rvalid, 1'b1);
      chkw("full_drain_rdata", rdata, 32'(i + 2));
      step();
    end
    settle();
    chkb("full_empty_rvalid", rvalid, 1'b0);
    chkb("full_empty_r_ready", r_ready, 1'b0);
    r_valid = 1'b0;

    // ---------------- ordering: R arrives before B ----------------
    idle();
    req = 1'b1; we = 1'b1; addr = 32'h100; aw_ready = 1'b1; w_ready = 1'b1;
    settle();
    chkb("ord_wr_gnt", gnt, 1'b1);
    step();
    we = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b1;
    settle();
    chkb("ord_rd_gnt", gnt, 1'b1);
    step();
    idle();
    r_valid = 1'b1; r_data = 32'h12345678; rready = 1'b1;
    settle();
    chkb("ord_r_ready_blocked", r_ready, 1'b0);
    chkb("ord_rvalid_blocked", rvalid, 1'b0);
    step();
    b_valid = 1'b1;
    settle();
    chkb("ord_wr_rvalid", rvalid, 1'b1);
    chkw("ord_wr_rdata", rdata, 32'h0);
    chkb("ord_wr_r_ready", r_ready, 1'b0);
    step();
    b_valid = 1'b0;
    settle();
    chkb("ord_rd_rvalid", rvalid, 1'b1);
    chkw("ord_rd_rdata", rdata, 32'h12345678);
    chkb("ord_rd_r_ready", r_ready, 1'b1);
    step();
    r_valid = 1'b0;

    // ---------------- back-pressure ----------------
    idle();
    req = 1'b1; we = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
    settle();
    chkb("bp_gnt", gnt, 1'b1);
    step();
    idle();
    b_valid = 1'b1; rready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chkb("bp_b_ready", b_ready, 1'b0);
      chkb("bp_rvalid_held", rvalid, 1'b1);
      step();
    end
    rready = 1'b1;
    settle();
    chkb("bp_release_b_ready", b_ready, 1'b1);
    step();
    settle();
    chkb("bp_popped_rvalid", rvalid, 1'b0);
    b_valid = 1'b0;

    // ---------------- reset mid-write ----------------
    idle();
    req = 1'b1; we = 1'b0; ar_ready = 1'b1;
    settle();
    chkb("rm_rd_gnt", gnt, 1'b1);
    step();
    ar_ready = 1'b0; we = 1'b1; addr = 32'h300; aw_ready = 1'b1; w_ready = 1'b0;
    settle();
    chkb("rm_aw_valid", aw_valid, 1'b1);
    chkb("rm_gnt", gnt, 1'b0);
    step();
    aw_ready = 1'b0;
    settle();
    chkb("rm_aw_done", aw_valid, 1'b0);
    w_ready = 1'b1; ar_ready = 1'b1;
    rst = 1'b1;
    settle();
    chkb("rm_in_rst_gnt", gnt, 1'b0);
    chkb("rm_in_rst_w_valid", w_valid, 1'b0);
    step();
    rst = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    r_valid = 1'b1; rready = 1'b1;
    settle();
    chkb("rm_after_aw_valid", aw_valid, 1'b1);
    chkb("rm_after_w_valid", w_valid, 1'b1);
    chkb("rm_late_r_rvalid", rvalid, 1'b0);
    chkb("rm_late_r_ready", r_ready, 1'b0);
    idle();
    step();

    // ---------------- randomized run ----------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    b_pend = 0; aw_seen = 0; w_seen = 0;
    drop_req = 0; drop_b = 0; drop_r = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit full, empty, head_wr;
      bit e_gnt, e_ar, e_aw, e_w, e_rvalid, e_bready, e_rready;
      logic [31:0] e_rdata;

      if (drop_req) req = 1'b0;
      if (drop_b)   b_valid = 1'b0;
      if (drop_r)   r_valid = 1'b0;
      drop_req = 0; drop_b = 0; drop_r = 0;

      if (!req && $urandom_range(0, 2) != 0) begin
        req = 1'b1;
        we = 1'($urandom_range(0, 1));
        addr = $urandom;
        be = 4'($urandom);
        wdata = $urandom;
      end
      aw_ready = 1'($urandom_range(0, 1));
      w_ready  = 1'($urandom_range(0, 1));
      ar_ready = 1'($urandom_range(0, 1));
      rready   = ($urandom_range(0, 3) == 0) ? 1'b0 : (cyc % 400 < 120 ? 1'b0 : 1'b1);
      if (!b_valid && b_pend > 0 && $urandom_range(0, 1) == 1) begin
        b_valid = 1'b1; b_resp = 2'($urandom);
      end
      if (!r_valid && slave_rq.size() > 0 && $urandom_range(0, 1) == 1) begin
        r_valid = 1'b1; r_data = slave_rq[0]; r_resp = 2'($urandom);
      end
      settle();

      full    = (outq.size() == MT);
      empty   = (outq.size() == 0);
      head_wr = empty ? 1'b0 : outq[0].is_wr;
      e_ar = req && !we && !full;
      e_aw = req && we && !full && !aw_seen;
      e_w  = req && we && !full && !w_seen;
      e_gnt = req && !full && (we ? ((aw_seen || aw_ready) && (w_seen || w_ready)) : ar_ready);
      e_rvalid = !empty && (head_wr ? b_valid : r_valid);
      e_bready = !empty && head_wr && rready;
      e_rready = !empty && !head_wr && rready;
      e_rdata  = (!empty && !head_wr) ? r_data : 32'h0;

      chkb("rnd_gnt", gnt, e_gnt);
      chkb("rnd_ar_valid", ar_valid, e_ar);
      chkb("rnd_aw_valid", aw_valid, e_aw);
      chkb("rnd_w_valid", w_valid, e_w);
      chkb("rnd_rvalid", rvalid, e_rvalid);
      chkb("rnd_b_ready", b_ready, e_bready);
      chkb("rnd_r_ready", r_ready, e_rready);
      chkw("rnd_rdata", rdata, e_rdata);
      if (e_ar) chkw("rnd_ar_addr", ar_addr, addr);
      if (e_aw) chkw("rnd_aw_addr", aw_addr, addr);
      if (e_w) begin
        chkw("rnd_w_data", w_data, wdata);
        chkw("rnd_w_strb", {28'b0, w_strb}, {28'b0, be});
      end
      if (e_rvalid && rready) chkw("rnd_resp_order", rdata, outq[0].data);

      // Advance the model to the state after the coming clock edge.
      if (e_rvalid && rready) void'(outq.pop_front());
      if (b_valid && e_bready) begin b_pend--; drop_b = 1; end
      if (r_valid && e_rready) begin void'(slave_rq.pop_front()); drop_r = 1; end
      if (e_gnt) begin
        if (we) begin
          b_pend++;
          outq.push_back('{is_wr: 1'b1, data: 32'h0});
        end else begin
          logic [31:0] d;
          d = $urandom;
          slave_rq.push_back(d);
          outq.push_back('{is_wr: 1'b0, data: d});
        end
        aw_seen = 0; w_seen = 0; drop_req = 1;
      end else begin
        if (e_aw && aw_ready) aw_seen = 1;
        if (e_w && w_ready)   w_seen = 1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adam_axil_from_obi.md
ADAM_AXIL_FROM_OBI -- requirements
Module: adam_axil_from_obi

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of the OBI and AXI-Lite sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_TRANS, default 4, maximum outstanding transactions; power of two, >= 2.
REQ-004 SHALL have seq.clk  input  1  sole clock, rising edge (ADAM_SEQ.Slave seq).
REQ-005 SHALL have seq.rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have OBI slave ports: req in 1; gnt out 1; addr in ADDR_WIDTH; we in 1; be in DATA_WIDTH/8; wdata in DATA_WIDTH; rvalid out 1; rready in 1; rdata out DATA_WIDTH.
REQ-007 SHALL have axil (AXI_LITE.Master): aw/w/ar/b/r channels with valid/ready, addr, data, strb, resp.

Function
REQ-008 SHALL keep an in-order type FIFO, depth MAX_TRANS, 1 = write, 0 = read, and a count of width clog2(MAX_TRANS)+1.
REQ-009 SHALL treat full as count == MAX_TRANS; when full: gnt = 0 and aw_valid = w_valid = ar_valid = 0.
REQ-010 SHALL drive read (req & !we & !full): ar_valid = 1, ar_addr = addr, gnt = ar_ready; push 0 on gnt.
REQ-011 SHALL drive write (req & we & !full): aw_valid = !aw_done, w_valid = !w_done, aw_addr = addr, w_data = wdata, w_strb = be.
REQ-012 SHALL set aw_done on an AW handshake without gnt, and w_done on a W handshake without gnt; both clear on gnt.
REQ-013 SHALL assert write gnt = (aw_done | aw_ready) & (w_done | w_ready) in the same cycle as the last handshake; push 1 on gnt.
REQ-014 SHALL allow AW and W handshakes in the same cycle or in any order over multiple cycles; a valid once raised is held until its handshake.
REQ-015 SHALL drive aw_prot = ar_prot = 0; AXI b_resp/r_resp are consumed and discarded.
REQ-016 SHALL, when FIFO head = 1: rvalid = b_valid, b_ready = rready, rdata = 0, r_ready = 0.
REQ-017 SHALL, when FIFO head = 0: rvalid = r_valid, rdata = r_data, r_ready = rready, b_ready = 0.
REQ-018 SHALL hold b_ready = r_ready = 0 and rvalid = 0 when the FIFO is empty.
REQ-019 SHALL pop the FIFO on rvalid & rready.
REQ-020 SHALL keep count unchanged on simultaneous push and pop, including push while full-then-popping (push still blocked that cycle by REQ-009).
REQ-021 SHALL wrap FIFO pointers modulo MAX_TRANS.
REQ-022 SHALL have zero-cycle request latency (gnt combinational from AXI ready) and zero-cycle response latency (rvalid combinational from b_valid/r_valid).
REQ-023 SHALL not register OBI request attributes; the OBI master holds req/addr/we/be/wdata stable until gnt.

Reset
REQ-024 SHALL, on seq.rst = 1 (asynchronous), clear count, FIFO pointers, aw_done, w_done.
REQ-025 SHALL output during reset: gnt = 0, rvalid = 0, rdata = 0, all AXI valids = 0, b_ready = r_ready = 0.
REQ-026 SHALL discard all outstanding transactions on reset mid-operation; late AXI responses after reset are not forwarded (FIFO empty).

Verification
REQ-027 Read: req=1, we=0, addr=0x40, ar_ready=1 -> gnt=1 same cycle; r_valid with r_data=0xDEADBEEF -> rvalid=1, rdata=0xDEADBEEF.
REQ-028 Split write: aw_ready=1 cycle 0, w_ready=0 until cycle 3 -> aw_valid drops cycle 1, w_valid held, gnt=1 only cycle 3; b_valid -> rvalid=1, rdata=0.
REQ-029 Full: 4 reads granted, no responses -> 5th req sees gnt=0, ar_valid=0; one R returned -> 5th granted the following cycle.
REQ-030 Ordering: write then read issued; slave returns R before B -> r_ready=0 until B consumed; OBI sees write response then 0x12345678.
REQ-031 Back-pressure: rready=0 with b_valid=1 -> b_ready=0, count unchanged; rready=1 -> pop.
REQ-032 Reset mid-write with aw_done=1 -> after release aw_valid re-asserted on next write req, count=0.
